// File: rtl/instr_stream_fifo.sv
// Flash lane assembler feeding a first-word fall-through instruction FIFO.
// Reports level/almost_full/full and a sticky overflow; flush clears all.
module instr_stream_fifo #(
  parameter int LANE_W      = 4,
  parameter int INSTR_W     = 20,
  parameter int DEPTH       = 4,
  parameter int AFULL_LEVEL = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [LANE_W-1:0]          in_data,
  input  logic                       in_valid,
  output logic [INSTR_W-1:0]         out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       almost_full,
  output logic                       full,
  output logic                       overflow
);

  localparam int BEATS = INSTR_W / LANE_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  localparam logic [CNT_W-1:0] LAST   = CNT_W'(BEATS - 1);
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_AF  = LVL_W'(AFULL_LEVEL);

  logic [INSTR_W-1:0] shift_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [INSTR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [LVL_W-1:0]   level_q;
  logic               ovf_q;

  logic [INSTR_W-1:0] word;
  logic               last;
  logic               pop;
  logic               push;
  logic               drop;
  logic               clr;

  // New beat enters at the LSBs, so the first beat ends up in the MSBs.
  assign word = (shift_q << LANE_W) | INSTR_W'(in_data);
  assign last = in_valid && (cnt_q == LAST);
  assign clr  = rst || flush;

  assign out_valid   = (level_q != '0);
  assign full        = (level_q == LVL_MAX);
  assign almost_full = (level_q >= LVL_AF);
  assign level       = level_q;
  assign overflow    = ovf_q;
  assign out_data    = out_valid ? mem[rd_ptr] : '0;

  assign pop  = out_valid && out_ready;
  assign push = last && (!full || pop);
  assign drop = last && full && !pop;

  always_ff @(posedge clk) begin
    if (clr) begin
      shift_q <= '0;
      cnt_q   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (in_valid) begin
        shift_q <= word;
        cnt_q   <= last ? '0 : cnt_q + CNT_W'(1);
      end
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
      if (drop) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr && push) mem[wr_ptr] <= word;
  end

endmodule

// File: tb/tb_instr_stream_fifo.sv
// Directed bench for instr_stream_fifo: default 4/20 build plus a 2/8 build.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_instr_stream_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [3:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic [19:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [2:0]  level;
  logic        almost_full;
  logic        full;
  logic        overflow;

  logic [1:0]  in_data2 = '0;
  logic        in_valid2 = 1'b0;
  logic [7:0]  out_data2;
  logic        out_valid2;
  logic        out_ready2 = 1'b0;
  logic [2:0]  level2;
  logic        almost_full2;
  logic        full2;
  logic        overflow2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_stream_fifo dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .almost_full(almost_full), .full(full),
    .overflow(overflow)
  );

  instr_stream_fifo #(.LANE_W(2), .INSTR_W(8)) dut2 (
    .clk(clk), .rst(rst), .flush(1'b0),
    .in_data(in_data2), .in_valid(in_valid2),
    .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2),
    .level(level2), .almost_full(almost_full2), .full(full2),
    .overflow(overflow2)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [3:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic word(input logic [19:0] w);
    for (int i = 4; i >= 0; i--) beat(w[i*4 +: 4]);
  endtask

  task automatic pop_expect(input string tag, input logic [19:0] w);
    chk(tag, {12'h0, out_data}, {12'h0, w});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic beat2(input logic [1:0] d);
    in_valid2 = 1'b1;
    in_data2  = d;
    tick();
    in_valid2 = 1'b0;
  endtask

  initial begin
    tick();
    rst = 1'b0;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_afull", 32'(almost_full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);

    // 1,2,3,4,5 back to back
    beat(4'h1); beat(4'h2); beat(4'h3); beat(4'h4);
    chk("t1_no_push", 32'(level), 32'd0);
    beat(4'h5);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_data", 32'(out_data), 32'h12345);
    chk("t1_level", 32'(level), 32'd1);
    chk("t1_afull", 32'(almost_full), 32'd0);
    pop_expect("t1_pop", 20'h12345);
    chk("t1_empty", 32'(out_valid), 32'd0);

    // gapped beats
    beat(4'hA); tick(); tick(); tick();
    beat(4'hB); tick(); tick(); tick();
    beat(4'hC); beat(4'hD);
    chk("t2_no_push", 32'(out_valid), 32'd0);
    beat(4'hE);
    chk("t2_data", 32'(out_data), 32'hABCDE);
    pop_expect("t2_pop", 20'hABCDE);

    // fill and overflow
    word(20'h11111); word(20'h22222);
    chk("t3_af_lvl2", 32'(almost_full), 32'd0);
    word(20'h33333);
    chk("t3_level3", 32'(level), 32'd3);
    chk("t3_afull", 32'(almost_full), 32'd1);
    chk("t3_notfull", 32'(full), 32'd0);
    word(20'h44444);
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_level4", 32'(level), 32'd4);
    chk("t3_ovf0", 32'(overflow), 32'd0);
    word(20'h55555);
    chk("t3_ovf1", 32'(overflow), 32'd1);
    chk("t3_level_ovf", 32'(level), 32'd4);
    pop_expect("t3_pop1", 20'h11111);
    chk("t3_level_pop", 32'(level), 32'd3);
    pop_expect("t3_pop2", 20'h22222);
    pop_expect("t3_pop3", 20'h33333);
    pop_expect("t3_pop4", 20'h44444);
    chk("t3_empty", 32'(out_valid), 32'd0);
    chk("t3_ovf_sticky", 32'(overflow), 32'd1);

    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_ovf", 32'(overflow), 32'd0);

    // push+pop at full
    word(20'h11111); word(20'h22222); word(20'h33333); word(20'h44444);
    beat(4'h6); beat(4'h6); beat(4'h6); beat(4'h6);
    in_valid = 1'b1; in_data = 4'h6; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("t4_level", 32'(level), 32'd4);
    chk("t4_full", 32'(full), 32'd1);
    chk("t4_ovf", 32'(overflow), 32'd0);
    pop_expect("t4_pop1", 20'h22222);
    pop_expect("t4_pop2", 20'h33333);
    pop_expect("t4_pop3", 20'h44444);
    pop_expect("t4_pop4", 20'h66666);
    chk("t4_empty", 32'(out_valid), 32'd0);

    // flush mid-word with a stored word
    word(20'h77777);
    beat(4'h1); beat(4'h2);
    flush = 1'b1; in_valid = 1'b1; in_data = 4'hF;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("t5_level", 32'(level), 32'd0);
    chk("t5_ovf", 32'(overflow), 32'd0);
    chk("t5_valid", 32'(out_valid), 32'd0);
    word(20'h98765);
    chk("t5_data", 32'(out_data), 32'h98765);

    // reset mid-word with two stored
    word(20'hAAAAA);
    beat(4'h1); beat(4'h2); beat(4'h3);
    chk("t6_pre_level", 32'(level), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_level", 32'(level), 32'd0);
    chk("t6_data", 32'(out_data), 32'd0);
    chk("t6_full", 32'(full), 32'd0);
    chk("t6_afull", 32'(almost_full), 32'd0);
    chk("t6_ovf", 32'(overflow), 32'd0);
    word(20'h13579);
    chk("t6_fresh", 32'(out_data), 32'h13579);
    chk("t6_fresh_lvl", 32'(level), 32'd1);

    // 2-bit lanes into 8-bit words: 3,2,1,0 -> 1110_0100
    beat2(2'd3); beat2(2'd2); beat2(2'd1);
    chk("w8_no_push", 32'(out_valid2), 32'd0);
    beat2(2'd0);
    chk("w8_data", 32'(out_data2), 32'hE4);
    chk("w8_level", 32'(level2), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
